// File: rtl/snake_pkg.sv
// Shared constants, types and helpers for the playfield background renderer.
package snake_pkg;

    localparam int RGB_W = 12;
    localparam int CNT_W = 11;

    localparam int HOR_PIX_DEF      = 1024;
    localparam int VER_PIX_DEF      = 768;
    localparam int GRID_SIZE_DEF    = 16;
    localparam int FRAME_X_SIZE_DEF = 40;
    localparam int FRAME_Y_SIZE_DEF = 20;
    localparam int FRAME_WIDTH_DEF  = 1;
    localparam int FLASH_FRAMES_DEF = 8;
    localparam int FLASH_CYCLES_DEF = 3;

    localparam logic [RGB_W-1:0] BG_COLOR_DEF      = 12'hd_a_5;
    localparam logic [RGB_W-1:0] BORDER_COLOR_DEF  = 12'h7_4_0;
    localparam logic [RGB_W-1:0] FLASH_COLOR_DEF   = 12'hf_0_0;
    localparam logic [RGB_W-1:0] FIELD_COLOR_A_DEF = 12'hd_a_5;
    localparam logic [RGB_W-1:0] FIELD_COLOR_B_DEF = 12'hc_9_4;

    typedef enum logic [1:0] {IDLE, FLASH_ON, FLASH_OFF} flash_state_t;

    typedef struct packed {
        logic [CNT_W-1:0] hcount;
        logic [CNT_W-1:0] vcount;
        logic             hsync;
        logic             hblnk;
        logic             vsync;
        logic             vblnk;
    } vga_timing_t;

    // Width of a counter that must hold values 0..max_val.
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/bg_flash_ctrl.sv
// Border flash sequencer: frame tick detection, request latch and on/off frame counting.
module bg_flash_ctrl
    import snake_pkg::*;
#(
    parameter int FLASH_FRAMES = FLASH_FRAMES_DEF,
    parameter int FLASH_CYCLES = FLASH_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic vsync_i,
    input  logic flash_req_i,
    output logic flash_on_o,
    output logic flash_busy_o
);

    localparam int FRM_W = cnt_width(FLASH_FRAMES - 1);
    localparam int CYC_W = cnt_width(FLASH_CYCLES - 1);
    localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(FLASH_FRAMES - 1);
    localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(FLASH_CYCLES - 1);

    flash_state_t     state_q;
    logic             vsync_q;
    logic             pending_q;
    logic [FRM_W-1:0] frm_q;
    logic [CYC_W-1:0] cyc_q;
    logic             tick;

    assign tick = vsync_i & ~vsync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            vsync_q   <= 1'b0;
            pending_q <= 1'b0;
            frm_q     <= '0;
            cyc_q     <= '0;
        end else begin
            vsync_q <= vsync_i;
            // Only a request seen in IDLE with nothing pending is latched.
            if (state_q == IDLE && !pending_q && flash_req_i) begin
                pending_q <= 1'b1;
            end
            unique case (state_q)
                IDLE: begin
                    if (tick && pending_q) begin
                        state_q   <= FLASH_ON;
                        pending_q <= 1'b0;
                        frm_q     <= '0;
                        cyc_q     <= '0;
                    end
                end
                FLASH_ON: begin
                    if (tick) begin
                        if (frm_q == FRM_LAST) begin
                            state_q <= FLASH_OFF;
                            frm_q   <= '0;
                        end else begin
                            frm_q <= frm_q + 1'b1;
                        end
                    end
                end
                FLASH_OFF: begin
                    if (tick) begin
                        if (frm_q == FRM_LAST) begin
                            frm_q <= '0;
                            if (cyc_q == CYC_LAST) begin
                                state_q <= IDLE;
                            end else begin
                                cyc_q   <= cyc_q + 1'b1;
                                state_q <= FLASH_ON;
                            end
                        end else begin
                            frm_q <= frm_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign flash_on_o   = (state_q == FLASH_ON);
    assign flash_busy_o = pending_q | (state_q != IDLE);

endmodule

// File: rtl/draw_playfield_bg.sv
// Playfield background stage: two-register region decode with flashable frame border.
module draw_playfield_bg
    import snake_pkg::*;
#(
    parameter int HOR_PIX      = HOR_PIX_DEF,
    parameter int VER_PIX      = VER_PIX_DEF,
    parameter int GRID_SIZE    = GRID_SIZE_DEF,
    parameter int FRAME_X_SIZE = FRAME_X_SIZE_DEF,
    parameter int FRAME_Y_SIZE = FRAME_Y_SIZE_DEF,
    parameter int FRAME_WIDTH  = FRAME_WIDTH_DEF,
    parameter logic [RGB_W-1:0] BG_COLOR      = BG_COLOR_DEF,
    parameter logic [RGB_W-1:0] BORDER_COLOR  = BORDER_COLOR_DEF,
    parameter logic [RGB_W-1:0] FLASH_COLOR   = FLASH_COLOR_DEF,
    parameter logic [RGB_W-1:0] FIELD_COLOR_A = FIELD_COLOR_A_DEF,
    parameter logic [RGB_W-1:0] FIELD_COLOR_B = FIELD_COLOR_B_DEF,
    parameter int FLASH_FRAMES = FLASH_FRAMES_DEF,
    parameter int FLASH_CYCLES = FLASH_CYCLES_DEF
) (
    input  logic             pclk,
    input  logic             rst,
    input  logic [CNT_W-1:0] hcount_in,
    input  logic [CNT_W-1:0] vcount_in,
    input  logic             hsync_in,
    input  logic             hblnk_in,
    input  logic             vsync_in,
    input  logic             vblnk_in,
    input  logic             checker_en,
    input  logic             flash_req,
    output logic [CNT_W-1:0] hcount_out,
    output logic [CNT_W-1:0] vcount_out,
    output logic             hsync_out,
    output logic             hblnk_out,
    output logic             vsync_out,
    output logic             vblnk_out,
    output logic [RGB_W-1:0] rgb_out,
    output logic             flash_busy,
    output logic [6:0]       field_x0_grid,
    output logic [5:0]       field_y0_grid,
    output logic [6:0]       field_w_grid,
    output logic [5:0]       field_h_grid
);

    localparam int X_OUT     = (HOR_PIX - FRAME_X_SIZE * GRID_SIZE) / 2;
    localparam int Y_OUT     = (VER_PIX - FRAME_Y_SIZE * GRID_SIZE) / 2;
    localparam int X_IN      = X_OUT + FRAME_WIDTH * GRID_SIZE;
    localparam int Y_IN      = Y_OUT + FRAME_WIDTH * GRID_SIZE;
    localparam int X_END     = X_OUT + FRAME_X_SIZE * GRID_SIZE;
    localparam int Y_END     = Y_OUT + FRAME_Y_SIZE * GRID_SIZE;
    localparam int X_IN_END  = X_END - FRAME_WIDTH * GRID_SIZE;
    localparam int Y_IN_END  = Y_END - FRAME_WIDTH * GRID_SIZE;
    localparam int GRID_LOG2 = $clog2(GRID_SIZE);
    localparam logic [CNT_W-1:0] X_IN_V = CNT_W'(X_IN);
    localparam logic [CNT_W-1:0] Y_IN_V = CNT_W'(Y_IN);

    if ((X_OUT % GRID_SIZE) != 0 || (Y_OUT % GRID_SIZE) != 0 ||
        (GRID_SIZE & (GRID_SIZE - 1)) != 0) begin : g_geom_err
        $error("draw_playfield_bg: frame origin not grid aligned or grid not a power of 2");
    end

    vga_timing_t      tim_in, tim1_q, tim2_q;
    logic             in_outer, in_inner, parity;
    logic             border1_q, field1_q, alt1_q;
    logic [RGB_W-1:0] rgb_d, rgb_q;
    logic             flash_on;

    assign tim_in = '{hcount: hcount_in, vcount: vcount_in, hsync: hsync_in,
                      hblnk: hblnk_in, vsync: vsync_in, vblnk: vblnk_in};

    // Origin is grid aligned, so the cell-parity bit of (h - X_IN) needs no subtraction.
    always_comb begin
        in_outer = (hcount_in >= CNT_W'(X_OUT)) && (hcount_in < CNT_W'(X_END)) &&
                   (vcount_in >= CNT_W'(Y_OUT)) && (vcount_in < CNT_W'(Y_END));
        in_inner = (hcount_in >= X_IN_V) && (hcount_in < CNT_W'(X_IN_END)) &&
                   (vcount_in >= Y_IN_V) && (vcount_in < CNT_W'(Y_IN_END));
        parity   = hcount_in[GRID_LOG2] ^ vcount_in[GRID_LOG2] ^
                   X_IN_V[GRID_LOG2] ^ Y_IN_V[GRID_LOG2];
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            tim1_q    <= '0;
            border1_q <= 1'b0;
            field1_q  <= 1'b0;
            alt1_q    <= 1'b0;
        end else begin
            tim1_q    <= tim_in;
            border1_q <= in_outer & ~in_inner;
            field1_q  <= in_inner;
            alt1_q    <= in_inner & checker_en & parity;
        end
    end

    always_comb begin
        rgb_d = BG_COLOR;
        if (tim1_q.hblnk || tim1_q.vblnk) begin
            rgb_d = '0;
        end else if (border1_q) begin
            rgb_d = flash_on ? FLASH_COLOR : BORDER_COLOR;
        end else if (field1_q) begin
            rgb_d = alt1_q ? FIELD_COLOR_B : FIELD_COLOR_A;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            tim2_q <= '0;
            rgb_q  <= '0;
        end else begin
            tim2_q <= tim1_q;
            rgb_q  <= rgb_d;
        end
    end

    bg_flash_ctrl #(
        .FLASH_FRAMES(FLASH_FRAMES),
        .FLASH_CYCLES(FLASH_CYCLES)
    ) u_flash_ctrl (
        .clk_i        (pclk),
        .rst_i        (rst),
        .vsync_i      (vsync_in),
        .flash_req_i  (flash_req),
        .flash_on_o   (flash_on),
        .flash_busy_o (flash_busy)
    );

    assign hcount_out    = tim2_q.hcount;
    assign vcount_out    = tim2_q.vcount;
    assign hsync_out     = tim2_q.hsync;
    assign hblnk_out     = tim2_q.hblnk;
    assign vsync_out     = tim2_q.vsync;
    assign vblnk_out     = tim2_q.vblnk;
    assign rgb_out       = rgb_q;
    assign field_x0_grid = 7'(X_IN / GRID_SIZE);
    assign field_y0_grid = 6'(Y_IN / GRID_SIZE);
    assign field_w_grid  = 7'(FRAME_X_SIZE - 2 * FRAME_WIDTH);
    assign field_h_grid  = 6'(FRAME_Y_SIZE - 2 * FRAME_WIDTH);

endmodule
